lineq_gj_sched: RTL and testbench
=================================

Name: lineq_gj_sched

Overview:
- Gauss-Jordan step scheduler for the lineq_solve matrix datapath.
- Takes the dimensions of an augmented M x (M+1) matrix of 32-bit words already held in the matrix store, and issues the full sequence of row operations to the row-op unit, one at a time, over a valid/ready/done handshake.
- Reports completion, a singular-pivot error, or a bad-dimension error.
- Holds no matrix data; it only sequences the datapath.

Parameters:
- MAX_DIM, 128, largest legal m_dim; matches the 128x128 matrix store.
- DIM_W, 8, width of dimension and row-index fields.
- CNT_W, 16, width of the issued-operation counter. Must hold MAX_DIM*MAX_DIM.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request to solve; sampled only in IDLE.
- m_dim  in  DIM_W  row count M; sampled with an accepted start.
- n_dim  in  DIM_W  column count; must equal M+1; sampled with an accepted start.
- op_valid  out  1  an operation is presented.
- op_ready  in  1  row-op unit accepts the operation; the handshake occurs when op_valid && op_ready.
- op_type  out  2  operation code: 0 = NORM (divide row op_pivot by its pivot element), 1 = ELIM (row op_row -= a[op_row][op_pivot] * row op_pivot).
- op_pivot  out  DIM_W  pivot row/column index k.
- op_row  out  DIM_W  target row i. Equals k for NORM.
- op_done  in  1  one-cycle pulse; the last accepted operation has finished.
- op_status  in  1  valid with op_done; 1 = zero pivot detected during a NORM.
- busy  out  1  high from the cycle after an accepted start until done asserts.
- done  out  1  one-cycle completion pulse, for success or error.
- err  out  2  0 = ok, 1 = bad dimension, 2 = singular. Held until the next accepted start.
- ops_issued  out  CNT_W  count of handshakes completed in the current run.

Behaviour:
- Reset values: state IDLE; op_valid, busy, done = 0; err = 0; ops_issued = 0; op_type, op_pivot, op_row = 0.
- IDLE:
  - start=1 latches m_dim and n_dim, clears err and ops_issued, and moves to CHECK. busy rises the next cycle.
- CHECK (one cycle):
  - Legal when 1 <= m_dim <= MAX_DIM and n_dim == m_dim+1.
  - Legal: set k=0 and go to ISSUE with NORM(k,k).
  - Illegal: err=1 and go to FIN.
- ISSUE:
  - op_valid=1. op_type, op_pivot and op_row are stable while op_valid && !op_ready.
  - On handshake: op_valid drops the next cycle, ops_issued increments by 1, go to WAIT.
- WAIT:
  - op_valid=0. Wait for op_done; op_done arriving in any other state is ignored.
  - op_done && op_status on a NORM: err=2, go to FIN. Remaining operations are aborted.
  - Otherwise advance to the next operation and return to ISSUE. op_valid reasserts exactly one cycle after op_done.
  - op_status on an ELIM is ignored.
- Operation order, for k = 0..M-1:
  - First NORM(k,k).
  - Then ELIM(k,i) for i = 0..M-1 ascending, skipping i=k.
  - After the last operation of k=M-1, go to FIN.
  - A full run issues exactly M*M operations. M=1 issues only NORM(0,0).
- FIN (one cycle):
  - done=1, busy drops in the same cycle, then IDLE.
  - err is valid in the done cycle and held afterwards.
- start while not in IDLE is ignored; it is neither queued nor restarts the run.
- Back-to-back runs: start may be accepted in the first IDLE cycle after FIN.
- Reset in any state returns all outputs to their reset values at the next edge.
  - Any operation in flight is abandoned; op_done following reset is ignored.
- Index arithmetic is unsigned DIM_W; i and k never exceed M-1.

Test Plan:
- m_dim=2, n_dim=3, start, op_ready=1, op_done 2 cycles after each handshake:
  - Issue order NORM(0,0), ELIM(0,1), NORM(1,1), ELIM(1,0).
  - ops_issued=4, done pulses once, err=0, busy low in the done cycle.
- m_dim=1, n_dim=2: a single NORM(0,0), then done with err=0, ops_issued=1.
- m_dim=2, n_dim=2; and separately m_dim=0, n_dim=1:
  - done 2 cycles after start, err=1, op_valid never asserted.
- m_dim=3, n_dim=4, op_ready held low 3 cycles on the second operation:
  - ELIM(0,1) fields stable throughout, exactly one handshake, ops_issued=9 at done.
- m_dim=3, n_dim=4, op_status=1 with the op_done of NORM(1,1):
  - err=2, ops_issued=4, done next cycle, no further op_valid.
- Mid-run checks on a 3x4 run:
  - start pulsed during the run is ignored.
  - reset asserted while in WAIT sets all outputs to 0 next edge; a late op_done is ignored.
  - A new start then runs a full 3x4 sequence of 9 operations.

Source files
------------

// File: rtl/lineq_gj_sched.sv
// Gauss-Jordan step scheduler: sequences NORM/ELIM row operations
// for an M x (M+1) augmented matrix over a valid/ready/done handshake.
module lineq_gj_sched #(
  parameter int MAX_DIM = 128,
  parameter int DIM_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] m_dim,
  input  logic [DIM_W-1:0] n_dim,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [1:0]       op_type,
  output logic [DIM_W-1:0] op_pivot,
  output logic [DIM_W-1:0] op_row,
  input  logic             op_done,
  input  logic             op_status,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] ops_issued
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  localparam logic [1:0] OP_NORM = 2'd0;
  localparam logic [1:0] OP_ELIM = 2'd1;
  localparam logic [1:0] E_OK    = 2'd0;
  localparam logic [1:0] E_DIM   = 2'd1;
  localparam logic [1:0] E_SING  = 2'd2;

  state_t           state_q, state_n;
  logic [DIM_W-1:0] m_q, m_n;
  logic [DIM_W-1:0] n_q, n_n;
  logic [DIM_W-1:0] k_q, k_n;
  logic [DIM_W-1:0] i_q, i_n;
  logic [1:0]       typ_q, typ_n;
  logic [1:0]       err_q, err_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic [DIM_W:0] m_x;
  logic [DIM_W:0] n_x;
  logic [DIM_W:0] k_x;
  logic [DIM_W:0] row_nxt;
  logic           legal;
  logic           last_k;

  assign m_x = {1'b0, m_q};
  assign n_x = {1'b0, n_q};
  assign k_x = {1'b0, k_q};

  assign legal = (m_x >= (DIM_W+1)'(1))
              && (m_x <= (DIM_W+1)'(MAX_DIM))
              && (n_x == m_x + (DIM_W+1)'(1));

  assign last_k = (k_x + (DIM_W+1)'(1)) == m_x;

  // Next target row for this pivot: the diagonal row is never eliminated.
  always_comb begin
    row_nxt = '0;
    if (typ_q == OP_ELIM) begin
      row_nxt = {1'b0, i_q} + (DIM_W+1)'(1);
    end
    if (row_nxt == k_x) begin
      row_nxt = row_nxt + (DIM_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
      typ_q   <= OP_NORM;
      err_q   <= E_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      m_q     <= m_n;
      n_q     <= n_n;
      k_q     <= k_n;
      i_q     <= i_n;
      typ_q   <= typ_n;
      err_q   <= err_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    m_n     = m_q;
    n_n     = n_q;
    k_n     = k_q;
    i_n     = i_q;
    typ_n   = typ_q;
    err_n   = err_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_n     = m_dim;
          n_n     = n_dim;
          err_n   = E_OK;
          cnt_n   = '0;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (legal) begin
          k_n     = '0;
          i_n     = '0;
          typ_n   = OP_NORM;
          state_n = S_ISSUE;
        end else begin
          err_n   = E_DIM;
          state_n = S_FIN;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          cnt_n   = cnt_q + CNT_W'(1);
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (op_done) begin
          if (typ_q == OP_NORM && op_status) begin
            err_n   = E_SING;
            state_n = S_FIN;
          end else if (row_nxt < m_x) begin
            typ_n   = OP_ELIM;
            i_n     = row_nxt[DIM_W-1:0];
            state_n = S_ISSUE;
          end else if (last_k) begin
            state_n = S_FIN;
          end else begin
            typ_n   = OP_NORM;
            k_n     = k_q + DIM_W'(1);
            i_n     = k_q + DIM_W'(1);
            state_n = S_ISSUE;
          end
        end
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign op_valid   = (state_q == S_ISSUE);
  assign busy       = (state_q == S_CHECK)
                   || (state_q == S_ISSUE)
                   || (state_q == S_WAIT);
  assign done       = (state_q == S_FIN);
  assign err        = err_q;
  assign ops_issued = cnt_q;
  assign op_type    = typ_q;
  assign op_pivot   = k_q;
  assign op_row     = i_q;

endmodule

// File: tb/tb_lineq_gj_sched.sv
// Randomized bench for lineq_gj_sched with a row-op unit responder
// and a loop-nest reference of the Gauss-Jordan operation order.
module tb_lineq_gj_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  m_dim;
  logic [7:0]  n_dim;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_type;
  logic [7:0]  op_pivot;
  logic [7:0]  op_row;
  logic        op_done;
  logic        op_status;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [15:0] ops_issued;

  int n_cmp = 0;
  int n_bad = 0;

  lineq_gj_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .m_dim      (m_dim),
    .n_dim      (n_dim),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_type    (op_type),
    .op_pivot   (op_pivot),
    .op_row     (op_row),
    .op_done    (op_done),
    .op_status  (op_status),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ops_issued (ops_issued)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {25'd0, op_valid, busy, done, err, ops_issued,
            op_type, op_pivot, op_row};
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic run(int m, int n, int fail_k, int rdy_pct,
                     int lat_lo, int lat_hi, int stall_op,
                     int abort_at, bit noise);
    int q[$];
    int exp_cnt;
    int exp_err;
    bit legal;
    int cyc = 0;
    int hs = 0;
    int cnt = 0;
    bit fin = 0;
    bit stalled = 0;
    int stall_left = 3;
    logic [17:0] last_f = '0;
    bit dsamp = 0;
    bit exp_end = 0;
    bit cur_norm = 0;
    bit cur_fail = 0;

    legal = (m >= 1) && (m <= 128) && (n == m + 1);
    exp_err = legal ? 0 : 1;
    if (legal) begin : build
      for (int k = 0; k < m; k++) begin
        q.push_back((0 << 16) | (k << 8) | k);
        if (k == fail_k) begin
          exp_err = 2;
          disable build;
        end
        for (int i = 0; i < m; i++)
          if (i != k) q.push_back((1 << 16) | (k << 8) | i);
      end
    end
    exp_cnt = q.size();

    start = 1'b1;
    m_dim = m[7:0];
    n_dim = n[7:0];
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start     = 1'b0;
      op_done   = 1'b0;
      op_status = 1'b0;
      op_ready  = 1'b0;
      if (abort_at > 0 && hs == abort_at && cnt > 0) begin
        reset = 1'b1;
        @(negedge clk);
        chk("rst_outs", all_outs(), 64'd0);
        reset   = 1'b0;
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        chk("late_done_valid", {63'd0, op_valid}, 64'd0);
        chk("late_done_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("idle_after_rst", all_outs(), 64'd0);
        return;
      end
      if (dsamp) begin
        if (exp_end) chk("done_after_last", {63'd0, done}, 64'd1);
        else chk("revalid", {63'd0, op_valid}, 64'd1);
        dsamp = 0;
      end
      if (cyc == 1) chk("busy_rise", {63'd0, busy}, 64'd1);
      if (done) begin
        fin = 1;
        chk("ops_issued", {48'd0, ops_issued}, 64'(exp_cnt));
        chk("err", {62'd0, err}, 64'(exp_err));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        chk("handshakes", 64'(hs), 64'(exp_cnt));
        if (!legal) chk("dim_latency", 64'(cyc), 64'd2);
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            op_done   = 1'b1;
            op_status = cur_norm ? cur_fail : 1'($urandom % 2);
            dsamp     = 1;
          end
        end
        if (op_valid) begin
          if (q.size() == 0) chk("unexpected_op", 64'd1, 64'd0);
          if (stalled)
            chk("stable", 64'({op_type, op_pivot, op_row}), 64'(last_f));
          if (stall_op == hs + 1 && stall_left > 0) begin
            stall_left--;
            op_ready = 1'b0;
          end else begin
            op_ready = 1'(($urandom % 100) < rdy_pct);
          end
          if (noise && !op_ready && ($urandom % 2) == 1) op_done = 1'b1;
          if (op_ready && q.size() > 0) begin
            chk("op", 64'({op_type, op_pivot, op_row}), 64'(q[0]));
            cur_norm = (q[0] >> 16) == 0;
            cur_fail = cur_norm && (((q[0] >> 8) & 255) == fail_k);
            void'(q.pop_front());
            hs++;
            exp_end = (q.size() == 0);
            cnt = int'($urandom_range(lat_hi, lat_lo));
            stalled = 0;
          end else begin
            stalled = 1;
            last_f = {op_type, op_pivot, op_row};
          end
        end
        if (noise && cyc >= 1 && ($urandom % 4) == 0) begin
          start = 1'b1;
          m_dim = 8'($urandom_range(7, 0));
          n_dim = 8'($urandom_range(8, 0));
        end
      end
    end
    if (!fin) begin
      chk("timeout", 64'd0, 64'd1);
      return;
    end
    start = 1'b0;
    op_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("idle_valid", {63'd0, op_valid}, 64'd0);
    chk("err_held", {62'd0, err}, 64'(exp_err));
  endtask

  initial begin
    int m;
    int n;
    reset     = 1'b1;
    start     = 1'b0;
    m_dim     = '0;
    n_dim     = '0;
    op_ready  = 1'b0;
    op_done   = 1'b0;
    op_status = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run(2, 3, -1, 100, 2, 2, 0, 0, 0);
    run(1, 2, -1, 100, 2, 2, 0, 0, 0);
    run(2, 2, -1, 100, 2, 2, 0, 0, 0);
    run(0, 1, -1, 100, 2, 2, 0, 0, 0);
    run(3, 4, -1, 100, 1, 3, 2, 0, 0);
    run(3, 4, 1, 100, 1, 3, 0, 0, 0);
    run(3, 4, -1, 60, 1, 3, 0, 0, 1);
    run(3, 4, -1, 100, 3, 3, 0, 3, 0);
    run(3, 4, -1, 100, 1, 2, 0, 0, 0);
    run(129, 130, -1, 100, 1, 2, 0, 0, 0);
    run(128, 129, 0, 100, 1, 2, 0, 0, 0);
    run(5, 5, -1, 100, 1, 2, 0, 0, 0);
    for (int r = 0; r < 12; r++) begin
      m = int'($urandom_range(6, 1));
      n = (($urandom % 5) == 0) ? m : m + 1;
      run(m, n, (($urandom % 3) == 0) ? int'($urandom_range(m - 1, 0)) : -1,
          int'($urandom_range(100, 40)), 1, 4,
          int'($urandom_range(3, 0)), 0, 1'($urandom % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
